mult_share_arbiter: RTL and testbench

//  Shares one in-order multiplier (karatsuba_ofman_mult: operands a|b packed in 2*DAT_BITS, ctl dropped)

---
 rtl/mult_arb_pkg.sv | 19 +
 rtl/tag_fifo.sv | 47 ++++
 rtl/mult_share_arbiter.sv | 130 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module  : mult_arb_pkg
// Shared requester-id type and helpers for the two-way multiplier arbiter.
// Rev 1.0
//==============================================================================
package mult_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic req_id_t;

  // With two requesters, the round-robin successor is simply the other one.
  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_fifo.sv
`default_nettype none
//==============================================================================
// Module  : tag_fifo
// Synchronous FIFO holding {id,ctl} tags for products still inside the multiplier.
// Rev 1.0
//==============================================================================
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  // One extra pointer bit separates the full and empty cases.
  logic [c_AW:0]      r_wr;
  logic [c_AW:0]      r_rd;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + (c_AW+1)'(1);
      if (i_pop)  r_rd <= r_rd + (c_AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr[c_AW-1:0]] <= i_dat;
  end

  assign o_dat   = r_mem[r_rd[c_AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : mult_share_arbiter
// Round-robin sharing of one in-order multiplier between two requesters.
// Rev 1.0
//==============================================================================
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int DAT_BITS = 256,
  parameter int CTL_BITS = 8,
  parameter int MAX_OUT  = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_REQ-1:0][2*DAT_BITS-1:0]    i_req_dat,
  input  logic [NUM_REQ-1:0][CTL_BITS-1:0]      i_req_ctl,
  input  logic [NUM_REQ-1:0]                    i_req_val,
  output logic [NUM_REQ-1:0]                    o_req_rdy,
  output logic [NUM_REQ-1:0][2*DAT_BITS-1:0]    o_rsp_dat,
  output logic [NUM_REQ-1:0][CTL_BITS-1:0]      o_rsp_ctl,
  output logic [NUM_REQ-1:0]                    o_rsp_val,
  input  logic [NUM_REQ-1:0]                    i_rsp_rdy,
  output logic [2*DAT_BITS-1:0]                 o_mul_dat,
  output logic                                  o_mul_val,
  input  logic                                  i_mul_rdy,
  input  logic [2*DAT_BITS-1:0]                 i_mul_dat,
  input  logic                                  i_mul_val,
  output logic                                  o_mul_rdy,
  output logic                                  o_err
);

  typedef struct packed {
    req_id_t             id;
    logic [CTL_BITS-1:0] ctl;
  } mult_tag_t;

  localparam int                c_TAG_W = $bits(mult_tag_t);
  localparam int                c_CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX  = c_CNT_W'(MAX_OUT);

  logic [2*DAT_BITS-1:0] r_mul_dat;
  logic                  r_mul_val;
  logic [c_CNT_W-1:0]    r_count;
  req_id_t               r_rr;
  logic                  r_err;

  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_can_accept;
  logic                  w_push;
  logic                  w_pop;
  req_id_t               w_acc_id;
  mult_tag_t             w_tag_in;
  mult_tag_t             w_head;
  logic [c_TAG_W-1:0]    w_head_raw;
  logic                  w_full;
  logic                  w_empty;

  always_comb begin
    w_grant = i_req_val;
    if (&i_req_val) begin
      w_grant       = '0;
      w_grant[r_rr] = 1'b1;
    end
  end

  // Held low during reset so nothing is accepted on the reset edge.
  assign w_can_accept = (~r_mul_val | i_mul_rdy) & (r_count < c_MAX) & ~w_full & i_rst;
  assign o_req_rdy    = w_grant & {NUM_REQ{w_can_accept}};
  assign w_push       = |o_req_rdy;
  assign w_acc_id     = o_req_rdy[1];
  assign w_tag_in.id  = w_acc_id;
  assign w_tag_in.ctl = i_req_ctl[w_acc_id];
  assign w_pop        = i_mul_val & o_mul_rdy;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mul_val <= 1'b0;
      r_rr      <= 1'b0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push)         r_mul_val <= 1'b1;
      else if (i_mul_rdy) r_mul_val <= 1'b0;
      if (w_push)         r_rr      <= other_req(w_acc_id);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      if (i_mul_val && w_empty) r_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mul_dat <= i_req_dat[w_acc_id];
  end

  assign o_mul_dat = r_mul_dat;
  assign o_mul_val = r_mul_val;
  assign o_err     = r_err;

  tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (c_TAG_W)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_dat   (w_tag_in),
    .i_pop   (w_pop),
    .o_dat   (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head = w_head_raw;

  // Products come back in issue order, so the FIFO head names their owner.
  always_comb begin
    o_rsp_val = '0;
    o_mul_rdy = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_rsp_dat[k] = i_mul_dat;
      o_rsp_ctl[k] = w_head.ctl;
    end
    if (!w_empty) begin
      o_rsp_val[w_head.id] = i_mul_val;
      o_mul_rdy            = i_rsp_rdy[w_head.id];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : tb_mult_share_arbiter
// Directed bench with a transaction-level arbiter model and a latency-4 multiplier.
// Rev 1.0
//==============================================================================
module tb_mult_share_arbiter;

  localparam int DB  = 8;
  localparam int CB  = 8;
  localparam int MO  = 8;
  localparam int LAT = 4;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] ctl; } req_t;
  typedef struct { int k; logic [7:0] a; logic [7:0] b; logic [7:0] ctl; } txn_t;
  typedef struct { logic [15:0] p; int t; } mq_t;
  typedef struct { int k; logic [15:0] d; logic [7:0] c; } rsp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0][15:0] req_dat = '0;
  logic [1:0][7:0]  req_ctl = '0;
  logic [1:0]       req_val = '0;
  logic [1:0]       req_rdy;
  logic [1:0][15:0] rsp_dat;
  logic [1:0][7:0]  rsp_ctl;
  logic [1:0]       rsp_val;
  logic [1:0]       rsp_rdy = 2'b11;
  logic [15:0]      mul_odat;
  logic             mul_oval;
  logic             mul_irdy;
  logic [15:0]      mul_idat;
  logic             mul_ival;
  logic             mul_ordy;
  logic             err;

  logic             m_val = 1'b0;
  logic [15:0]      m_dat = '0;
  logic             inj = 1'b0;
  logic             mrdy_en = 1'b1;
  logic             tog_en = 1'b0;
  logic             tick = 1'b0;
  int               cyc = 0;

  int    checks = 0;
  int    errors = 0;
  int    n_acc  = 0;
  req_t  drv_q [2][$];
  int    acc_log[$];
  rsp_t  rsp_log[$];
  mq_t   mq[$];
  txn_t  out_q[$];
  txn_t  iss_q[$];
  int    rr = 0;
  bit    m_err = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    tick <= ~tick;
    cyc  <= cyc + 1;
  end

  assign mul_ival = m_val | inj;
  assign mul_idat = inj ? 16'hdead : m_dat;
  assign mul_irdy = mrdy_en & (~tog_en | tick);

  mult_share_arbiter #(.DAT_BITS(DB), .CTL_BITS(CB), .MAX_OUT(MO)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_dat(req_dat), .i_req_ctl(req_ctl), .i_req_val(req_val), .o_req_rdy(req_rdy),
    .o_rsp_dat(rsp_dat), .o_rsp_ctl(rsp_ctl), .o_rsp_val(rsp_val), .i_rsp_rdy(rsp_rdy),
    .o_mul_dat(mul_odat), .o_mul_val(mul_oval), .i_mul_rdy(mul_irdy),
    .i_mul_dat(mul_idat), .i_mul_val(mul_ival), .o_mul_rdy(mul_ordy),
    .o_err(err)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Requester drivers: hold each request until its handshake edge.
  always @(posedge clk) begin
    logic [1:0] acc;
    acc = req_val & req_rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        void'(drv_q[k].pop_front());
        acc_log.push_back(k);
        n_acc++;
      end
      req_val[k] = (drv_q[k].size() > 0);
      if (drv_q[k].size() > 0) begin
        req_dat[k] = {drv_q[k][0].b, drv_q[k][0].a};
        req_ctl[k] = drv_q[k][0].ctl;
      end
    end
  end

  // Fixed-latency in-order multiplier that stalls its output on backpressure.
  always @(posedge clk) begin
    logic [15:0] pr;
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (m_val && mul_ordy) void'(mq.pop_front());
      if (mul_oval && mul_irdy) begin
        pr = 16'(mul_odat[7:0]) * 16'(mul_odat[15:8]);
        mq.push_back('{pr, cyc + LAT});
      end
    end
    #1;
    m_val = (mq.size() > 0) && (mq[0].t <= cyc);
    m_dat = m_val ? mq[0].p : 16'h0;
  end

  // Transaction model: outstanding list in acceptance order, one issue slot, rr winner.
  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    logic [1:0] exp_rval;
    logic       exp_mrdy;
    logic [15:0] exp_p;
    bit         can;
    bit         was_empty;
    int         win;
    int         h;
    txn_t       t;
    if (!rst_n) begin
      out_q.delete();
      iss_q.delete();
      rr    = 0;
      m_err = 1'b0;
    end else begin
      can = ((iss_q.size() == 0) || mul_irdy) && (out_q.size() < MO);
      win = (req_val == 2'b11) ? rr : (req_val[1] ? 1 : 0);
      exp_rdy = (can && req_val != 2'b00) ? (2'b01 << win) : 2'b00;
      check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      check("mul_val", 64'(mul_oval), 64'(iss_q.size() > 0));
      if (iss_q.size() > 0) check("mul_dat", 64'(mul_odat), 64'({iss_q[0].b, iss_q[0].a}));
      exp_rval = 2'b00;
      exp_mrdy = 1'b0;
      h = 0;
      was_empty = (out_q.size() == 0);
      if (!was_empty) begin
        h = out_q[0].k;
        exp_rval[h] = mul_ival;
        exp_mrdy    = rsp_rdy[h];
      end
      check("rsp_val", 64'(rsp_val), 64'(exp_rval));
      check("mul_rdy", 64'(mul_ordy), 64'(exp_mrdy));
      if (!was_empty && mul_ival) begin
        exp_p = 16'(out_q[0].a) * 16'(out_q[0].b);
        check("rsp_dat", 64'(rsp_dat[h]), 64'(exp_p));
        check("rsp_ctl", 64'(rsp_ctl[h]), 64'(out_q[0].ctl));
      end
      check("err", 64'(err), 64'(m_err));
      if (!was_empty && mul_ival && rsp_rdy[h]) begin
        rsp_log.push_back('{h, rsp_dat[h], rsp_ctl[h]});
        void'(out_q.pop_front());
      end
      if (was_empty && mul_ival) m_err = 1'b1;
      if (iss_q.size() > 0 && mul_irdy) void'(iss_q.pop_front());
      if (exp_rdy != 2'b00) begin
        t = '{win, req_dat[win][7:0], req_dat[win][15:8], req_ctl[win]};
        iss_q.push_back(t);
        out_q.push_back(t);
        rr = 1 - win;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drv_q[k].push_back('{a, b, c});
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((out_q.size() > 0 || iss_q.size() > 0 || drv_q[0].size() > 0 ||
            drv_q[1].size() > 0) && n < 400) begin
      step(1);
      n++;
    end
    check(nm, 64'(n < 400), 64'(1));
    step(2);
  endtask

  initial begin
    int n0;
    int nr;
    int exp_ord[4];
    int exp_prd[4];
    exp_ord = '{0, 1, 0, 1};
    exp_prd = '{63, 156, 51000, 65025};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", 64'(req_rdy), 64'(0));
    check("rst_mul_val", 64'(mul_oval), 64'(0));
    check("rst_rsp_val", 64'(rsp_val), 64'(0));
    check("rst_mul_rdy", 64'(mul_ordy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    step(1);
    rst_n = 1'b1;
    step(1);

    // 1: single requester
    push(0, 8'd3, 8'd5, 8'h11);
    wait_idle("t1_idle");
    check("t1_count", 64'(rsp_log.size()), 64'(1));
    check("t1_port", 64'(rsp_log[0].k), 64'(0));
    check("t1_dat", 64'(rsp_log[0].d), 64'(15));
    check("t1_ctl", 64'(rsp_log[0].c), 64'(8'h11));

    // 2: both valid, round-robin from pointer 0, multiplier rdy toggling
    pulse_reset();
    acc_log.delete();
    nr = rsp_log.size();
    tog_en = 1'b1;
    push(0, 8'd7,   8'd9,   8'd0);
    push(1, 8'd12,  8'd13,  8'd1);
    push(0, 8'd200, 8'd255, 8'd2);
    push(1, 8'd255, 8'd255, 8'd3);
    wait_idle("t2_idle");
    tog_en = 1'b0;
    check("t2_nacc", 64'(acc_log.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check("t2_order", 64'(acc_log[i]), 64'(exp_ord[i]));
      check("t2_port", 64'(rsp_log[nr+i].k), 64'(exp_ord[i]));
      check("t2_prod", 64'(rsp_log[nr+i].d), 64'(exp_prd[i]));
      check("t2_ctl", 64'(rsp_log[nr+i].c), 64'(i));
    end

    // 3: head-of-line blocking behind a stalled owner
    rsp_rdy = 2'b10;
    push(0, 8'd2, 8'd3, 8'h30);
    step(2);
    push(1, 8'd4, 8'd5, 8'h31);
    step(15);
    check("t3_hol_val", 64'(rsp_val), 64'(2'b01));
    check("t3_hol_mrdy", 64'(mul_ordy), 64'(0));
    check("t3_hol_dat", 64'(rsp_dat[0]), 64'(6));
    nr = rsp_log.size();
    rsp_rdy = 2'b11;
    wait_idle("t3_idle");
    check("t3_first", 64'(rsp_log[nr].k), 64'(0));
    check("t3_second", 64'(rsp_log[nr+1].k), 64'(1));
    check("t3_dat", 64'(rsp_log[nr+1].d), 64'(20));

    // 4: outstanding limit, then exactly one more after one retire
    rsp_rdy = 2'b00;
    n0 = n_acc;
    for (int i = 0; i < 12; i++) push(0, 8'(i + 1), 8'(i + 2), 8'(8'h40 + i));
    step(40);
    check("t4_acc8", 64'(n_acc - n0), 64'(8));
    check("t4_rdy_low", 64'(req_rdy), 64'(0));
    rsp_rdy = 2'b01;
    step(1);
    rsp_rdy = 2'b00;
    step(10);
    check("t4_acc9", 64'(n_acc - n0), 64'(9));
    rsp_rdy = 2'b11;
    wait_idle("t4_idle");

    // 5: product with no outstanding tag
    inj = 1'b1;
    step(1);
    inj = 1'b0;
    step(4);
    check("t5_err_set", 64'(err), 64'(1));
    step(3);
    check("t5_err_sticky", 64'(err), 64'(1));
    pulse_reset();
    check("t5_err_clr", 64'(err), 64'(0));

    // 6: reset with three products outstanding
    rsp_rdy = 2'b00;
    push(0, 8'd9,  8'd9,  8'h60);
    push(1, 8'd10, 8'd10, 8'h61);
    push(0, 8'd11, 8'd11, 8'h62);
    step(20);
    check("t6_pending", 64'(rsp_val), 64'(2'b01));
    rst_n = 1'b0;
    step(1);
    check("t6_mul_val", 64'(mul_oval), 64'(0));
    check("t6_rsp_val", 64'(rsp_val), 64'(0));
    check("t6_mul_rdy", 64'(mul_ordy), 64'(0));
    check("t6_req_rdy", 64'(req_rdy), 64'(0));
    check("t6_err", 64'(err), 64'(0));
    rst_n = 1'b1;
    rsp_rdy = 2'b11;
    step(1);
    nr = rsp_log.size();
    push(1, 8'd6, 8'd7, 8'h66);
    wait_idle("t6_idle");
    check("t6_new_n", 64'(rsp_log.size() - nr), 64'(1));
    check("t6_new_port", 64'(rsp_log[nr].k), 64'(1));
    check("t6_new_dat", 64'(rsp_log[nr].d), 64'(42));
    check("t6_new_ctl", 64'(rsp_log[nr].c), 64'(8'h66));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
